// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared types and sizes for the serial-audio receive path
package audio_pkg;

  localparam int SAMPLE_WIDTH  = 24;
  localparam int ERR_CNT_WIDTH = 8;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } rx_state_t;

endpackage

// File: rtl/serial_deserializer.sv
// rtl/serial_deserializer.sv - MSB-first shift register with saturating bit count
module serial_deserializer #(
  parameter  int WIDTH = 24,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load_first,
  input  logic             shift,
  input  logic             sd,
  output logic [WIDTH-1:0] word,
  output logic [CW-1:0]    count,
  output logic             full
);

  assign full = (count == CW'(WIDTH));

  // Bits arriving after the word is full are dropped; count sticks at WIDTH.
  always_ff @(posedge clk) begin
    if (clear) begin
      word  <= '0;
      count <= '0;
    end else if (load_first) begin
      word  <= {{(WIDTH-1){1'b0}}, sd};
      count <= CW'(1);
    end else if (shift && !full) begin
      word  <= {word[WIDTH-2:0], sd};
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/adc_receiver.sv
// rtl/adc_receiver.sv - left-justified serial-audio receiver; ADC_RECEIVER_ERROR_COUNT_EN adds error_count
module adc_receiver
  import audio_pkg::*;
#(
  parameter int WIDTH = SAMPLE_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             lrclk,
  input  logic             sd,
  output logic [WIDTH-1:0] left_data,
  output logic [WIDTH-1:0] right_data,
  output logic             valid,
  output logic             frame_error
`ifdef ADC_RECEIVER_ERROR_COUNT_EN
  ,
  output logic [ERR_CNT_WIDTH-1:0] error_count
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  rx_state_t        state, state_nxt;
  logic             lrclk_q, rise, fall, clear;
  logic             load_l, shift_l, load_r, shift_r, capture, err;
  logic [WIDTH-1:0] word_l, word_r;
  logic [CW-1:0]    count_l, count_r;
  logic             full_l, full_r;

  assign rise  = lrclk & ~lrclk_q;
  assign fall  = ~lrclk & lrclk_q;
  assign clear = rst | ~enable;

  // lrclk_q resets high so a line already high out of reset is not a rise.
  always_ff @(posedge clk) begin
    if (rst) lrclk_q <= 1'b1;
    else     lrclk_q <= lrclk;
  end

  always_ff @(posedge clk) begin
    if (clear) state <= SYNC;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_l    = 1'b0;
    shift_l   = 1'b0;
    load_r    = 1'b0;
    shift_r   = 1'b0;
    capture   = 1'b0;
    err       = 1'b0;
    case (state)
      SYNC: begin
        if (rise) begin
          load_l    = 1'b1;
          state_nxt = LEFT;
        end
      end
      LEFT: begin
        if (fall) begin
          if (count_l == CW'(WIDTH)) begin
            load_r    = 1'b1;
            state_nxt = RIGHT;
          end else begin
            err       = 1'b1;
            state_nxt = SYNC;
          end
        end else begin
          shift_l = ~full_l;
        end
      end
      RIGHT: begin
        // A rise always opens the next left word; it is an error only if the right word was short.
        if (rise) begin
          load_l    = 1'b1;
          err       = ~full_r;
          state_nxt = LEFT;
        end else begin
          shift_r = ~full_r;
          capture = (count_r == CW'(WIDTH - 1));
        end
      end
      default: state_nxt = SYNC;
    endcase
  end

  serial_deserializer #(.WIDTH(WIDTH)) u_left (
    .clk       (clk),
    .clear     (clear),
    .load_first(load_l),
    .shift     (shift_l),
    .sd        (sd),
    .word      (word_l),
    .count     (count_l),
    .full      (full_l)
  );

  serial_deserializer #(.WIDTH(WIDTH)) u_right (
    .clk       (clk),
    .clear     (clear),
    .load_first(load_r),
    .shift     (shift_r),
    .sd        (sd),
    .word      (word_r),
    .count     (count_r),
    .full      (full_r)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      left_data   <= '0;
      right_data  <= '0;
      valid       <= 1'b0;
      frame_error <= 1'b0;
    end else if (!enable) begin
      valid       <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      valid       <= capture;
      frame_error <= err;
      if (capture) begin
        left_data  <= word_l;
        right_data <= (word_r << 1) | {{(WIDTH-1){1'b0}}, sd};
      end
    end
  end

`ifdef ADC_RECEIVER_ERROR_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      error_count <= '0;
    else if (frame_error && (error_count != {ERR_CNT_WIDTH{1'b1}}))
      error_count <= error_count + ERR_CNT_WIDTH'(1);
  end
`endif

endmodule

// File: tb/tb_adc_receiver.sv
// tb/tb_adc_receiver.sv - randomized frame-level bench for adc_receiver
module tb_adc_receiver;

  localparam int W = 24;

  logic         clk = 1'b0;
  logic         rst, enable, lrclk, sd;
  logic [W-1:0] left_data, right_data;
  logic         valid, frame_error;
`ifdef ADC_RECEIVER_ERROR_COUNT_EN
  logic [7:0]   error_count;
`endif

  adc_receiver #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .lrclk      (lrclk),
    .sd         (sd),
    .left_data  (left_data),
    .right_data (right_data),
    .valid      (valid),
    .frame_error(frame_error)
`ifdef ADC_RECEIVER_ERROR_COUNT_EN
    ,
    .error_count(error_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] l;
    logic [W-1:0] r;
    int           nl;
    int           nr;
  } frame_t;

  frame_t       frames[$];
  logic [W-1:0] cur_l = '0;
  logic [W-1:0] cur_r = '0;
  int           exp_errs = 0;
  int           checks = 0;
  int           failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic add(input logic [W-1:0] l, input logic [W-1:0] r, input int nl, input int nr);
    frame_t f;
    f.l = l; f.r = r; f.nl = nl; f.nr = nr;
    frames.push_back(f);
  endtask

  task automatic step(input bit l, input bit d, input bit ev, input bit efe);
    @(negedge clk);
    lrclk = l;
    sd    = d;
    @(posedge clk);
    #1;
    check("valid", valid, ev);
    check("frame_error", frame_error, efe);
    check("left_data", left_data, cur_l);
    check("right_data", right_data, cur_r);
  endtask

  // Expected strobes come from frame rules: short left -> error at the fall, full left+right ->
  // sample after the last right bit, short right -> error at the next rise.
  task automatic run_frames();
    bit           lr_q[$], sd_q[$], v_q[$], fe_q[$];
    logic [W-1:0] l_q[$], r_q[$];
    bit           short_right = 1'b0;
    for (int i = 0; i < 2; i++) begin
      lr_q.push_back(1'b0); sd_q.push_back(1'($urandom));
      v_q.push_back(1'b0); fe_q.push_back(1'b0); l_q.push_back('0); r_q.push_back('0);
    end
    foreach (frames[f]) begin
      int p = lr_q.size();
      for (int k = 0; k < frames[f].nl + frames[f].nr; k++) begin
        bit is_left = (k < frames[f].nl);
        int b = is_left ? k : k - frames[f].nl;
        logic [W-1:0] w = is_left ? frames[f].l : frames[f].r;
        lr_q.push_back(is_left);
        sd_q.push_back((b < W) ? w[W-1-b] : 1'($urandom));
        v_q.push_back(1'b0); fe_q.push_back(1'b0); l_q.push_back('0); r_q.push_back('0);
      end
      if (short_right) fe_q[p] = 1'b1;
      if (frames[f].nl < W) begin
        fe_q[p + frames[f].nl] = 1'b1;
        short_right = 1'b0;
      end else if (frames[f].nr >= W) begin
        v_q[p + frames[f].nl + W - 1] = 1'b1;
        l_q[p + frames[f].nl + W - 1] = frames[f].l;
        r_q[p + frames[f].nl + W - 1] = frames[f].r;
        short_right = 1'b0;
      end else begin
        short_right = 1'b1;
      end
    end
    foreach (lr_q[i]) begin
      if (v_q[i]) begin
        cur_l = l_q[i];
        cur_r = r_q[i];
      end
      if (fe_q[i]) exp_errs++;
      step(lr_q[i], sd_q[i], v_q[i], fe_q[i]);
    end
    frames.delete();
`ifdef ADC_RECEIVER_ERROR_COUNT_EN
    check("error_count", error_count, (exp_errs > 255) ? 255 : exp_errs);
`endif
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] rl, rr;
    int nl, nr;
    rst = 1'b1; enable = 1'b1; lrclk = 1'b1; sd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_left", left_data, 0);
    check("rst_right", right_data, 0);
    check("rst_valid", valid, 0);
    check("rst_ferr", frame_error, 0);
`ifdef ADC_RECEIVER_ERROR_COUNT_EN
    check("rst_errcnt", error_count, 0);
`endif
    @(negedge clk);
    rst = 1'b0;

    repeat (3) add(24'hA5A5A5, 24'h5A5A5A, W, W);
    add(24'h800000, 24'h7FFFFF, W, W);
    add(24'h000000, 24'hFFFFFF, W, W);
    add(24'hDEADBE, 24'hEF0123, 20, W);
    add(24'h123456, 24'h654321, W, W);
    add(24'h0F0F0F, 24'hF0F0F0, W, 10);
    add(24'h13579B, 24'h2468AC, W, W);
    run_frames();

    for (int i = 0; i < 20; i++) begin
      rl = W'($urandom);
      rr = W'($urandom);
      nl = ($urandom_range(0, 6) == 0) ? int'($urandom_range(1, W - 1)) : W;
      nr = ($urandom_range(0, 6) == 0) ? int'($urandom_range(1, W - 1)) : W;
      add(rl, rr, nl, nr);
    end
    add(24'hC0FFEE, 24'hBADA55, W, W);
    run_frames();

    for (int k = 0; k < 12; k++) step(1'b1, 1'($urandom), 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    cur_l = '0;
    cur_r = '0;
    exp_errs = 0;
    @(posedge clk);
    #1;
    check("midrst_left", left_data, 0);
    check("midrst_right", right_data, 0);
    check("midrst_valid", valid, 0);
    check("midrst_ferr", frame_error, 0);
    @(negedge clk);
    rst = 1'b0;
    add(24'h314159, 24'h271828, W, W);
    run_frames();

    for (int k = 0; k < W; k++) step(1'b1, 1'($urandom), 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) step(1'b0, 1'($urandom), 1'b0, 1'b0);
    @(negedge clk);
    enable = 1'b0;
    for (int k = 0; k < 14; k++) step(1'b0, 1'($urandom), 1'b0, 1'b0);
    enable = 1'b1;
    add(24'hABCDEF, 24'hFEDCBA, W, W);
    add(24'h00FF00, 24'hFF00FF, W, W);
    run_frames();

`ifdef ADC_RECEIVER_ERROR_COUNT_EN
    for (int i = 0; i < 300; i++)
      add(W'($urandom), W'($urandom), int'($urandom_range(1, W - 1)), 1);
    run_frames();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("errcnt_rst", error_count, 0);
    @(negedge clk);
    rst = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_receiver.md
Name: adc_receiver

Overview:
- Serial-audio receiver for the left-justified format: MSB first, WIDTH bits per channel, lrclk high = left.
- Lrclk edges coincide with the MSB, as produced by dac_transmitter and by the board ADC.
- Deserialises left and right words and presents them as a parallel stereo sample with a one-cycle valid strobe.
- Sits between the ADC pins (or a loopback from dac_transmitter) and the synth/effects sample path.

Parameters:
- WIDTH, 24, bits per channel word.

Ports:
- clk  input  1  serial bit clock, 2*WIDTH*44.1 kHz; all logic on posedge clk.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  receiver run enable.
- lrclk  input  1  word select from the line; high = left.
- sd  input  1  serial data from the line, MSB first.
- left_data  output  WIDTH  last complete left word.
- right_data  output  WIDTH  last complete right word.
- valid  output  1  one-cycle strobe; left_data/right_data updated this cycle.
- frame_error  output  1  one-cycle strobe on a short channel word.

Behaviour:
- Sampling and edge detection:
  - lrclk and sd are sampled on posedge clk; the transmitter drives them on negedge.
  - lrclk_q holds the previous lrclk sample.
  - rise = lrclk & ~lrclk_q; fall = ~lrclk & lrclk_q.
- Reset (rst=1 at posedge):
  - state=SYNC, bit count=0, lrclk_q=1 (so a line already high is not taken as a rise).
  - left_data=0, right_data=0, valid=0, frame_error=0, shift registers=0.
  - Reset mid-word discards the partial frame.
- enable=0:
  - Same as reset, except left_data/right_data hold their values.
  - valid=0, frame_error=0.
  - lrclk_q still tracks lrclk.
- States:
  - SYNC: ignore sd until a rise.
  - On rise: shift_l <= {WIDTH-1'b0, sd}, count=1, go to LEFT. The rise cycle's sd is the left MSB.
  - LEFT, on fall:
    - If count==WIDTH: shift_r <= sd, count=1, go to RIGHT.
    - Else: frame_error pulse, go to SYNC.
  - LEFT, otherwise: if count<WIDTH, shift in sd and increment count. Bits beyond WIDTH are ignored and count saturates at WIDTH.
  - RIGHT, shifting: same as LEFT. On the cycle the WIDTH-th right bit is shifted in:
    - left_data <= shift_l, right_data <= {shift_r[WIDTH-2:0], sd}.
    - valid=1 on the following cycle (registered, with the data).
    - Latency: valid is high one clk after the last right LSB is sampled.
  - RIGHT, on rise: start a new left word (as from SYNC), go to LEFT.
    - If count<WIDTH at that rise: frame_error pulse; no valid for that frame.
  - RIGHT, on fall: impossible by definition; ignored.
- Strobes: valid and frame_error are each exactly one cycle wide and never high in the same cycle.
- Steady state: one valid every 2*WIDTH clk.

Optional Feature:
- Macro: ADC_RECEIVER_ERROR_COUNT_EN.
- Defined:
  - Extra output error_count, 8 bits.
  - Increments on each frame_error pulse and saturates at 255.
  - Cleared only by rst; enable has no effect on it.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package audio_pkg: state enum (SYNC, LEFT, RIGHT), SAMPLE_WIDTH default 24, ERR_CNT_WIDTH=8.
- One natural sub-module: serial_deserializer (WIDTH).
  - Inputs: clear, load_first, shift, sd.
  - Outputs: word, count, full.
  - Instantiated twice, for left and right.
- Edge detect and FSM stay in adc_receiver.

Test Plan:
- Loopback: dac_transmitter (WIDTH=24) driving lrclk/sd with L=24'hA5A5A5, R=24'h5A5A5A, enable both → first valid within 2 frames; left_data=A5A5A5, right_data=5A5A5A; valid exactly every 48 clk.
- Extremes: L=24'h800000, R=24'h7FFFFF, then L=0, R=24'hFFFFFF → each pair reproduced bit-exact on consecutive valid pulses; no frame_error.
- Short left word: lrclk falls after 20 left bits → frame_error one cycle, no valid; next full frame L=24'h123456, R=24'h654321 received correctly.
- Short right word: rise after 10 right bits → frame_error; the new left word starting on that rise is captured correctly and the next valid carries it.
- Reset/enable mid-frame: rst at left bit 12 → all outputs 0; enable=0 mid right word → outputs hold, no valid; resume on the next rise.
- With ADC_RECEIVER_ERROR_COUNT_EN: 300 short frames → error_count=255 (saturated); rst → 0.
